seg7_scan: RTL and testbench
============================

# seg7_scan

Memory-mapped 4-digit multiplexed 7-segment display controller. Consumes the 16-bit packed BCD time (mm:ss) from the real-time clock peripheral, or a CPU-written hex value, and drives common-anode digit strobes and segment lines with PWM brightness and a blinking seconds colon. Sits on the same memory bus as the RTC, directly downstream of its time output.

## Interface
Parameters:
- SUB_DIV, 2250, clk_in cycles per brightness sub-phase; one digit slot = 16 sub-phases (36 MHz → 1 kHz per digit, 250 Hz frame)

Ports:
- clk_in  input  1  clock
- reset  input  1  reset, synchronous, active-high
- address_in  input  32  bus address; only bit 2 decoded (0 = CTRL, 1 = DATA)
- sel_in  input  1  bus select
- read_value_out  output  32  read data, combinational; 0 when sel_in low
- write_mask_in  input  4  byte write enables; bit n covers bits 8n+7:8n
- write_value_in  input  32  write data
- ready_out  output  1  equals sel_in, combinational
- time_bcd_in  input  16  {minHi, minLo, secHi, secLo} BCD time
- seg_out  output  7  segments a..g on bits 0..6, active-low, registered
- dp_out  output  1  decimal point, active-low, registered
- digit_out  output  4  anode strobes, bit 3 leftmost, active-low, registered

## Operation
- CTRL: bit0 SRC (0 = time_bcd_in, 1 = DATA), bit1 EN, bit2 LZB (see Configuration), bits 11:8 BRIGHT; other bits read 0. Reset value 0x0000_0F02.
- DATA: bits 15:0 four hex digits (15:12 = digit 3), bits 19:16 DP per digit; other bits read 0. Reset 0.
- Writes take effect on the clk_in edge where sel_in=1 and the mask byte is set; a write with mask 0 is ignored.
- Counters: sub-divider 0..SUB_DIV-1; on wrap, 4-bit phase increments; on phase wrap 15→0, digit index increments 3→0 wrap (digit 0 → 1 → 2 → 3 → 0).
- Snapshot: 16-bit digit value and 4-bit DP are latched into a shadow register when digit index enters 0 (and on first cycle after reset). Mid-frame changes to time_bcd_in or DATA never mix into one frame.
- Selected digit nibble decoded as hex 0–F (standard glyphs; A,b,C,d,E,F); BCD values >9 display hex glyphs, no error.
- Colon: SRC=0 → digit 2 DP lit when snapshot secLo bit0 = 0, other DPs off. SRC=1 → DP from DATA[19:16].
- Digit driven when EN=1 and phase ≤ BRIGHT (BRIGHT 0 = 1/16 duty, 15 = full); otherwise digit_out=4'hF, seg_out=7'h7F, dp_out=1.
- EN 1→0 blanks on the next edge; counters keep running.

## Timing
- Reset: seg_out=7'h7F, dp_out=1, digit_out=4'hF, counters 0, digit index 0, CTRL/DATA to reset values. Reset mid-scan restarts at digit 0 phase 0.
- Outputs registered: a change of digit index, phase or CTRL is visible one cycle after the causing edge; digit_out and seg_out always switch on the same edge (no cross-digit ghosting).
- Digit slot = 16·SUB_DIV cycles; frame = 64·SUB_DIV cycles.
- Bus reads: zero latency, combinational from register state; read during write returns old value.
- Snapshot latency: new time_bcd_in visible at most one frame + 1 cycle later.

## Configuration
- SEG7_LZB_EN defined: CTRL bit2 writable; when LZB=1 and snapshot digit 3 = 0, digit 3 stays blank (strobe high) in its slot; digit 2 is never suppressed.
- Undefined: CTRL bit2 reads 0, writes ignored, no suppression logic present.

## Test plan
- Reset, SUB_DIV=2, time_bcd_in=16'h1234 → digit_out cycles E,D,B,7 pattern (digit 0 first), segments show 4,3,2,1 glyphs; each slot 32 cycles.
- Write CTRL=0x0003, DATA=0x000A_BCDE → digits show E,d,C,b; DP lit only on digits 1 and 3.
- BRIGHT=3 → each digit strobed low exactly 4·SUB_DIV of 16·SUB_DIV slot cycles; BRIGHT=0 → 1·SUB_DIV.
- Change time_bcd_in 0x0059→0x0100 while digit 2 active → current frame keeps 0059 glyphs; next frame shows 0100; colon lit on 0100 (secLo=0), off on 0059.
- With SEG7_LZB_EN, LZB=1, time 0x0945 → digit 3 strobe stays high, others normal; without macro, read CTRL after writing 0x0F06 → 0x0F02.
- Assert reset mid-slot with EN=1 → next cycle outputs 7F/1/F, scan resumes at digit 0.

Source files
------------

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - memory-mapped 4-digit multiplexed 7-segment display controller
//
// Scans four common-anode digits from either the RTC packed-BCD time (mm:ss)
// or a CPU-written hex value, with 16-step PWM brightness and a seconds colon.
// Optional leading-zero blanking of digit 3 is built only when SEG7_LZB_EN
// is defined.
//
// Ports:
//   clk_in          clock
//   reset           synchronous, active-high reset
//   address_in      bus address, bit 2 selects CTRL (0) / DATA (1)
//   sel_in          bus select
//   read_value_out  combinational read data, 0 when not selected
//   write_mask_in   byte write enables
//   write_value_in  write data
//   ready_out       bus ready, mirrors sel_in
//   time_bcd_in     {minHi, minLo, secHi, secLo} from the RTC
//   seg_out         segments a..g on bits 0..6, active-low, registered
//   dp_out          decimal point, active-low, registered
//   digit_out       anode strobes, bit 3 leftmost, active-low, registered

module seg7_scan #(
    parameter int SUB_DIV = 2250
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out,
    input  logic [15:0] time_bcd_in,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic [3:0]  digit_out
);

    localparam int SUB_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(SUB_DIV - 1);

    logic             r_src;
    logic             r_en;
    logic [3:0]       r_bright;
    logic [19:0]      r_data;
    logic [SUB_W-1:0] r_sub;
    logic [3:0]       r_phase;
    logic [1:0]       r_digit;
    logic             r_load;
    logic [15:0]      r_snap_val;
    logic [3:0]       r_snap_dp;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic [3:0]       r_digit_out;

    logic             w_sub_wrap;
    logic             w_phase_wrap;
    logic             w_frame_wrap;
    logic             w_wr_ctrl;
    logic             w_wr_data;
    logic             w_lzb_rd;
    logic             w_suppress;
    logic             w_drive;
    logic [3:0]       w_nib;
    logic [6:0]       w_glyph;
    logic [15:0]      w_src_val;
    logic [3:0]       w_src_dp;
    logic             w_unused;

    assign w_unused = ^{address_in[31:3], address_in[1:0], write_value_in[31:20]};

`ifdef SEG7_LZB_EN
    logic r_lzb;
    assign w_lzb_rd   = r_lzb;
    // Only the leftmost digit is ever blanked; digit 2 always shows its zero.
    assign w_suppress = r_lzb && (r_digit == 2'd3) && (r_snap_val[15:12] == 4'h0);
`else
    assign w_lzb_rd   = 1'b0;
    assign w_suppress = 1'b0;
`endif

    assign ready_out = sel_in;
    assign w_wr_ctrl = sel_in && !address_in[2];
    assign w_wr_data = sel_in && address_in[2];

    always_comb begin
        read_value_out = 32'h0;
        if (sel_in) begin
            if (address_in[2]) begin
                read_value_out = {12'h000, r_data};
            end else begin
                read_value_out = {20'h00000, r_bright, 5'b00000, w_lzb_rd, r_en, r_src};
            end
        end
    end

    // Register writes; reads above see the pre-edge value.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_src    <= 1'b0;
            r_en     <= 1'b1;
            r_bright <= 4'hF;
            r_data   <= 20'h00000;
`ifdef SEG7_LZB_EN
            r_lzb    <= 1'b0;
`endif
        end else begin
            if (w_wr_ctrl && write_mask_in[0]) begin
                r_src <= write_value_in[0];
                r_en  <= write_value_in[1];
`ifdef SEG7_LZB_EN
                r_lzb <= write_value_in[2];
`endif
            end
            if (w_wr_ctrl && write_mask_in[1]) r_bright      <= write_value_in[11:8];
            if (w_wr_data && write_mask_in[0]) r_data[7:0]   <= write_value_in[7:0];
            if (w_wr_data && write_mask_in[1]) r_data[15:8]  <= write_value_in[15:8];
            if (w_wr_data && write_mask_in[2]) r_data[19:16] <= write_value_in[19:16];
        end
    end

    assign w_sub_wrap   = (r_sub == SUB_MAX);
    assign w_phase_wrap = w_sub_wrap && (r_phase == 4'hF);
    assign w_frame_wrap = w_phase_wrap && (r_digit == 2'd3);

    // In time mode the colon sits on digit 2 and blinks with the seconds LSB.
    assign w_src_val = r_src ? r_data[15:0]  : time_bcd_in;
    assign w_src_dp  = r_src ? r_data[19:16] : {1'b0, ~time_bcd_in[0], 2'b00};

    // Scan counters and the per-frame snapshot; the snapshot reloads exactly
    // when the digit index returns to 0 so one frame never mixes two values.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_sub      <= '0;
            r_phase    <= 4'h0;
            r_digit    <= 2'd0;
            r_load     <= 1'b1;
            r_snap_val <= time_bcd_in;
            r_snap_dp  <= {1'b0, ~time_bcd_in[0], 2'b00};
        end else begin
            r_load <= 1'b0;
            r_sub  <= w_sub_wrap ? '0 : r_sub + 1'b1;
            if (w_sub_wrap) r_phase <= r_phase + 4'h1;
            if (w_phase_wrap) r_digit <= r_digit + 2'd1;
            if (r_load || w_frame_wrap) begin
                r_snap_val <= w_src_val;
                r_snap_dp  <= w_src_dp;
            end
        end
    end

    always_comb begin
        w_nib = 4'h0;
        case (r_digit)
            2'd0:    w_nib = r_snap_val[3:0];
            2'd1:    w_nib = r_snap_val[7:4];
            2'd2:    w_nib = r_snap_val[11:8];
            default: w_nib = r_snap_val[15:12];
        endcase
    end

    // Active-high glyphs, bit 6..0 = g..a.
    always_comb begin
        w_glyph = 7'h00;
        case (w_nib)
            4'h0: w_glyph = 7'h3F;
            4'h1: w_glyph = 7'h06;
            4'h2: w_glyph = 7'h5B;
            4'h3: w_glyph = 7'h4F;
            4'h4: w_glyph = 7'h66;
            4'h5: w_glyph = 7'h6D;
            4'h6: w_glyph = 7'h7D;
            4'h7: w_glyph = 7'h07;
            4'h8: w_glyph = 7'h7F;
            4'h9: w_glyph = 7'h6F;
            4'hA: w_glyph = 7'h77;
            4'hB: w_glyph = 7'h7C;
            4'hC: w_glyph = 7'h39;
            4'hD: w_glyph = 7'h5E;
            4'hE: w_glyph = 7'h79;
            default: w_glyph = 7'h71;
        endcase
    end

    assign w_drive = r_en && (r_phase <= r_bright) && !w_suppress;

    // Strobe and segments come from one register stage so they always change
    // together.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_seg       <= 7'h7F;
            r_dp        <= 1'b1;
            r_digit_out <= 4'hF;
        end else if (w_drive) begin
            r_seg       <= ~w_glyph;
            r_dp        <= ~r_snap_dp[r_digit];
            r_digit_out <= ~(4'b0001 << r_digit);
        end else begin
            r_seg       <= 7'h7F;
            r_dp        <= 1'b1;
            r_digit_out <= 4'hF;
        end
    end

    assign seg_out   = r_seg;
    assign dp_out    = r_dp;
    assign digit_out = r_digit_out;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - self-checking bench for seg7_scan

module tb_seg7_scan;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address_in = 32'h0;
    logic        sel_in = 1'b0;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in = 4'h0;
    logic [31:0] write_value_in = 32'h0;
    logic        ready_out;
    logic [15:0] time_bcd_in = 16'h0;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  digit_out;

    always #5 clk_in = ~clk_in;

    seg7_scan #(.SUB_DIV(2)) dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .address_in     (address_in),
        .sel_in         (sel_in),
        .read_value_out (read_value_out),
        .write_mask_in  (write_mask_in),
        .write_value_in (write_value_in),
        .ready_out      (ready_out),
        .time_bcd_in    (time_bcd_in),
        .seg_out        (seg_out),
        .dp_out         (dp_out),
        .digit_out      (digit_out)
    );

    // Active-low glyphs, bit 0 = segment a.
    localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30;
    localparam logic [6:0] G4 = 7'h19, G5 = 7'h12, G7 = 7'h78;
    localparam logic [6:0] G8 = 7'h00, G9 = 7'h10, GB = 7'h03, GC = 7'h46;
    localparam logic [6:0] GD = 7'h21, GE = 7'h06, GF = 7'h0E;
    localparam logic [11:0] BLANK = {4'hF, 7'h7F, 1'b1};

`ifdef SEG7_LZB_EN
    localparam logic [3:0]  LZB_MASK = 4'b1000;
    localparam logic [31:0] CTRL_F06 = 32'h0000_0F06;
    localparam logic [31:0] CTRL_ALL = 32'h0000_0F07;
`else
    localparam logic [3:0]  LZB_MASK = 4'b0000;
    localparam logic [31:0] CTRL_F06 = 32'h0000_0F02;
    localparam logic [31:0] CTRL_ALL = 32'h0000_0F03;
`endif

    int errors = 0;
    int checks = 0;
    int tcount = 0;

    typedef struct {
        int          cyc;
        logic [11:0] exp;
        string       name;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [31:0]      ctrl;
        logic [31:0]      data;
        logic [15:0]      tim;
        logic [3:0][6:0]  seg;
        logic [3:0]       dp;
        logic [3:0]       blank;
        string            name;
    } vec_t;
    vec_t vecs[7];

    // Edges since reset release; outputs seen after edge t reflect scan count t-1.
    always @(posedge clk_in) begin
        if (reset) tcount <= 0;
        else       tcount <= tcount + 1;
    end

    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic expect_at(int cyc, logic [11:0] exp, string nm);
        sb_t e;
        e.cyc  = cyc;
        e.exp  = exp;
        e.name = nm;
        sb.push_back(e);
    endtask

    always @(negedge clk_in) begin
        sb_t e;
        while (sb.size() > 0 && sb[0].cyc <= tcount) begin
            e = sb.pop_front();
            if (e.cyc < tcount) check({e.name, "_missed"}, tcount, e.cyc);
            else check(e.name, {digit_out, seg_out, dp_out}, e.exp);
        end
    end

    task automatic wait_cyc(int n);
        int guard = 0;
        while (tcount < n && guard < 5000) begin
            @(negedge clk_in);
            guard++;
        end
        if (tcount < n) check("wait_cyc_timeout", tcount, n);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() > 0 && guard < 1000) begin
            @(negedge clk_in);
            guard++;
        end
        if (sb.size() > 0) check("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset = 1'b1;
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
    endtask

    task automatic bus_wr(logic [31:0] addr, logic [3:0] mask, logic [31:0] val);
        sel_in = 1'b1;
        address_in = addr;
        write_mask_in = mask;
        write_value_in = val;
        @(negedge clk_in);
        sel_in = 1'b0;
        write_mask_in = 4'h0;
    endtask

    task automatic bus_rd(logic [31:0] addr, output logic [31:0] v);
        sel_in = 1'b1;
        address_in = addr;
        #1;
        v = read_value_out;
        sel_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog tcount=%0d", tcount);
        $fatal(1);
    end

    initial begin
        logic [31:0] rv;
        logic [3:0]  oh;
        logic [11:0] lit;
        int          base;
        int          br;
        int          cnt;

        vecs[0] = '{32'h0F02, 32'h0, 16'h1234, {G1, G2, G3, G4}, 4'b1011, 4'b0000, "bcd1234"};
        vecs[1] = '{32'h0003, 32'h000A_BCDE, 16'h1234, {GB, GC, GD, GE}, 4'b0101, 4'b0000, "hexABCDE_b0"};
        vecs[2] = '{32'h0F02, 32'h0, 16'h0059, {G0, G0, G5, G9}, 4'b1111, 4'b0000, "bcd0059"};
        vecs[3] = '{32'h0F02, 32'h0, 16'h0100, {G0, G1, G0, G0}, 4'b1011, 4'b0000, "bcd0100"};
        vecs[4] = '{32'h0F03, 32'h0005_F789, 16'h0000, {GF, G7, G8, G9}, 4'b1010, 4'b0000, "hexF789"};
        vecs[5] = '{32'h0F06, 32'h0, 16'h0945, {G0, G9, G4, G5}, 4'b1111, LZB_MASK, "lzb0945"};
        vecs[6] = '{32'h0702, 32'h0, 16'h1234, {G1, G2, G3, G4}, 4'b1011, 4'b0000, "bcd1234_b7"};

        // Reset state and register reads
        repeat (3) @(negedge clk_in);
        check("rst_digit", digit_out, 4'hF);
        check("rst_seg", seg_out, 7'h7F);
        check("rst_dp", dp_out, 1'b1);
        check("ready_idle", ready_out, 1'b0);
        check("rd_unsel", read_value_out, 32'h0);
        bus_rd(32'h0, rv);
        check("rst_ctrl", rv, 32'h0000_0F02);
        bus_rd(32'h4, rv);
        check("rst_data", rv, 32'h0);
        sel_in = 1'b1;
        #1;
        check("ready_sel", ready_out, 1'b1);
        sel_in = 1'b0;
        @(negedge clk_in);
        reset = 1'b0;

        // Register write behaviour
        bus_wr(32'h0, 4'hF, 32'h0000_0F06);
        bus_rd(32'h0, rv);
        check("ctrl_f06", rv, CTRL_F06);
        bus_wr(32'h0, 4'h0, 32'h0000_0000);
        bus_rd(32'h0, rv);
        check("ctrl_mask0", rv, CTRL_F06);
        bus_wr(32'h0, 4'hF, 32'hFFFF_FFFF);
        bus_rd(32'h0, rv);
        check("ctrl_ones", rv, CTRL_ALL);
        bus_wr(32'h4, 4'b0101, 32'hFFFF_FFFF);
        bus_rd(32'h4, rv);
        check("data_bytemask", rv, 32'h000F_00FF);
        sel_in = 1'b1;
        address_in = 32'h4;
        write_mask_in = 4'hF;
        write_value_in = 32'h0001_2345;
        #1;
        check("rd_during_wr", read_value_out, 32'h000F_00FF);
        @(negedge clk_in);
        sel_in = 1'b0;
        write_mask_in = 4'h0;
        bus_rd(32'h4, rv);
        check("data_after_wr", rv, 32'h0001_2345);

        // Table-driven display vectors, checked over frame 1
        for (int i = 0; i < 7; i++) begin
            time_bcd_in = vecs[i].tim;
            do_reset();
            bus_wr(32'h0, 4'hF, vecs[i].ctrl);
            bus_wr(32'h4, 4'hF, vecs[i].data);
            br = int'(vecs[i].ctrl[11:8]);
            for (int d = 0; d < 4; d++) begin
                base = 128 + 32 * d;
                oh = 4'b0001 << d;
                lit = {~oh, vecs[i].seg[d], vecs[i].dp[d]};
                if (vecs[i].blank[d]) begin
                    expect_at(base + 1, BLANK, $sformatf("%s_d%0d_blank", vecs[i].name, d));
                end else begin
                    expect_at(base + 1, lit, $sformatf("%s_d%0d", vecs[i].name, d));
                    if (br < 15) begin
                        expect_at(base + 2 * br + 2, lit, $sformatf("%s_d%0d_lastlit", vecs[i].name, d));
                        expect_at(base + 2 * br + 3, BLANK, $sformatf("%s_d%0d_off", vecs[i].name, d));
                    end
                end
            end
            drain();
        end

        // PWM duty in digit 1 slot: BRIGHT=3 and BRIGHT=0
        for (int k = 0; k < 2; k++) begin
            time_bcd_in = 16'h1234;
            do_reset();
            bus_wr(32'h0, 4'hF, (k == 0) ? 32'h0302 : 32'h0002);
            cnt = 0;
            for (int t = 161; t <= 192; t++) begin
                wait_cyc(t);
                if (digit_out == 4'hD) cnt++;
            end
            check((k == 0) ? "duty_b3" : "duty_b0", cnt, (k == 0) ? 8 : 2);
        end

        // Snapshot: time changes while digit 2 is active in frame 1
        time_bcd_in = 16'h0059;
        do_reset();
        expect_at(193, {4'hB, G0, 1'b1}, "snap_f1_d2_start");
        expect_at(212, {4'hB, G0, 1'b1}, "snap_f1_d2_after_change");
        expect_at(225, {4'h7, G0, 1'b1}, "snap_f1_d3");
        expect_at(257, {4'hE, G0, 1'b1}, "snap_f2_d0");
        expect_at(289, {4'hD, G0, 1'b1}, "snap_f2_d1");
        expect_at(321, {4'hB, G1, 1'b0}, "snap_f2_d2_colon");
        wait_cyc(200);
        time_bcd_in = 16'h0100;
        drain();

        // Enable off blanks on the next edge; counters keep running
        time_bcd_in = 16'h1234;
        do_reset();
        expect_at(11, {4'hE, G4, 1'b1}, "en_before");
        expect_at(12, BLANK, "en_off_blank");
        expect_at(13, BLANK, "en_off_blank2");
        expect_at(70, {4'hB, G2, 1'b0}, "en_back_d2");
        wait_cyc(10);
        bus_wr(32'h0, 4'hF, 32'h0F00);
        wait_cyc(40);
        bus_wr(32'h0, 4'hF, 32'h0F02);
        drain();

        // Reset mid-slot
        wait_cyc(150);
        check("pre_rst_digit", digit_out, 4'hE);
        reset = 1'b1;
        @(posedge clk_in);
        #1;
        check("mid_rst_digit", digit_out, 4'hF);
        check("mid_rst_seg", seg_out, 7'h7F);
        check("mid_rst_dp", dp_out, 1'b1);
        @(negedge clk_in);
        reset = 1'b0;
        expect_at(1, {4'hE, G4, 1'b1}, "post_rst_d0");
        expect_at(33, {4'hD, G3, 1'b1}, "post_rst_d1");
        expect_at(65, {4'hB, G2, 1'b0}, "post_rst_d2");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
